// File: rtl/ascon_aead128_pkg.sv
// rtl/ascon_aead128_pkg.sv - shared state encoding and round-count defaults for the Ascon-AEAD128 sequencer
package ascon_aead128_pkg;

  localparam int ROUND_W          = 4;
  localparam int ROUNDS_A_DEFAULT = 12;
  localparam int ROUNDS_B_DEFAULT = 8;
  localparam int CNT_W_DEFAULT    = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_LOAD,
    S_INIT_PERM,
    S_INIT_KEY,
    S_AD_WAIT,
    S_AD_PERM,
    S_DSEP,
    S_MSG_WAIT,
    S_MSG_PERM,
    S_FIN_KEY,
    S_FIN_PERM,
    S_TAG
  } ctrl_state_t;

  function automatic logic is_perm_state(input ctrl_state_t s);
    return (s == S_INIT_PERM) || (s == S_AD_PERM) || (s == S_MSG_PERM) || (s == S_FIN_PERM);
  endfunction

endpackage

// File: rtl/ascon_aead128_sat_cnt.sv
// rtl/ascon_aead128_sat_cnt.sv - clearable block counter that sticks at all-ones
module ascon_aead128_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ascon_aead128_ctrl.sv
// rtl/ascon_aead128_ctrl.sv - Ascon-AEAD128 operation sequencer: orders datapath strobes and permutation launches
module ascon_aead128_ctrl
  import ascon_aead128_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int ROUNDS_B = ROUNDS_B_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic               no_ad,
  input  logic               ad_valid,
  input  logic               ad_last,
  output logic               ad_ready,
  input  logic               msg_valid,
  input  logic               msg_last,
  output logic               msg_ready,
  output logic               dec_mode,
  output logic               dp_load_init,
  output logic               dp_key_xor_tail,
  output logic               dp_absorb_ad,
  output logic               dp_dsep,
  output logic               dp_absorb_msg,
  output logic               dp_key_xor_final,
  output logic               dp_tag_out,
  output logic               perm_start,
  output logic [ROUND_W-1:0] perm_rounds,
  input  logic               perm_done,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ad_blk_cnt,
  output logic [CNT_W-1:0]   msg_blk_cnt
);

  ctrl_state_t state, nxt;
  logic        no_ad_q;
  logic        ad_last_q;
  logic        start_acc;
  logic        ad_hs;
  logic        msg_hs;
  logic        perm_entry;

  function automatic logic [ROUND_W-1:0] rounds_for(input ctrl_state_t s);
    return ((s == S_INIT_PERM) || (s == S_FIN_PERM)) ? ROUND_W'(ROUNDS_A) : ROUND_W'(ROUNDS_B);
  endfunction

  // ready is registered and only high in the wait states, so these are the handshakes
  assign start_acc     = (state == S_IDLE) && start;
  assign ad_hs         = ad_ready && ad_valid;
  assign msg_hs        = msg_ready && msg_valid;
  assign dp_absorb_ad  = ad_hs;
  assign dp_absorb_msg = msg_hs;
  assign perm_entry    = is_perm_state(nxt) && (nxt != state);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (start_acc) nxt = S_INIT_LOAD;
      S_INIT_LOAD: nxt = S_INIT_PERM;
      S_INIT_PERM: if (perm_done) nxt = S_INIT_KEY;
      S_INIT_KEY:  nxt = no_ad_q ? S_DSEP : S_AD_WAIT;
      S_AD_WAIT:   if (ad_hs) nxt = S_AD_PERM;
      S_AD_PERM:   if (perm_done) nxt = ad_last_q ? S_DSEP : S_AD_WAIT;
      S_DSEP:      nxt = S_MSG_WAIT;
      // the final message block goes straight to finalization without p^b
      S_MSG_WAIT:  if (msg_hs) nxt = msg_last ? S_FIN_KEY : S_MSG_PERM;
      S_MSG_PERM:  if (perm_done) nxt = S_MSG_WAIT;
      S_FIN_KEY:   nxt = S_FIN_PERM;
      S_FIN_PERM:  if (perm_done) nxt = S_TAG;
      S_TAG:       nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      no_ad_q          <= 1'b0;
      ad_last_q        <= 1'b0;
      dec_mode         <= 1'b0;
      ad_ready         <= 1'b0;
      msg_ready        <= 1'b0;
      dp_load_init     <= 1'b0;
      dp_key_xor_tail  <= 1'b0;
      dp_dsep          <= 1'b0;
      dp_key_xor_final <= 1'b0;
      dp_tag_out       <= 1'b0;
      done             <= 1'b0;
      perm_start       <= 1'b0;
      perm_rounds      <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= nxt;
      ad_ready         <= (nxt == S_AD_WAIT);
      msg_ready        <= (nxt == S_MSG_WAIT);
      dp_load_init     <= (nxt == S_INIT_LOAD);
      dp_key_xor_tail  <= (nxt == S_INIT_KEY);
      dp_dsep          <= (nxt == S_DSEP);
      dp_key_xor_final <= (nxt == S_FIN_KEY);
      dp_tag_out       <= (nxt == S_TAG);
      done             <= (nxt == S_TAG);
      busy             <= (nxt != S_IDLE);
      perm_start       <= perm_entry;
      perm_rounds      <= perm_entry ? rounds_for(nxt) : '0;
      if (start_acc) begin
        dec_mode <= decrypt;
        no_ad_q  <= no_ad;
      end
      if (ad_hs) begin
        ad_last_q <= ad_last;
      end
    end
  end

  ascon_aead128_sat_cnt #(.W(CNT_W)) u_ad_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .inc (ad_hs),
    .cnt (ad_blk_cnt)
  );

  ascon_aead128_sat_cnt #(.W(CNT_W)) u_msg_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .inc (msg_hs),
    .cnt (msg_blk_cnt)
  );

endmodule

// File: tb/tb_ascon_aead128_ctrl.sv
// tb/tb_ascon_aead128_ctrl.sv - scoreboard bench for the Ascon-AEAD128 sequencer
module tb_ascon_aead128_ctrl;

  localparam int E_LOAD = 1;
  localparam int E_TAIL = 2;
  localparam int E_AD   = 3;
  localparam int E_DSEP = 4;
  localparam int E_MSG  = 5;
  localparam int E_FIN  = 6;
  localparam int E_TAG  = 7;
  localparam int E_PERM = 16;

  logic        clk, rst, start, decrypt, no_ad;
  logic        ad_valid, ad_last, ad_ready, msg_valid, msg_last, msg_ready;
  logic        dec_mode, dp_load_init, dp_key_xor_tail, dp_absorb_ad, dp_dsep;
  logic        dp_absorb_msg, dp_key_xor_final, dp_tag_out, perm_start, perm_done;
  logic [3:0]  perm_rounds;
  logic        busy, done;
  logic [15:0] ad_blk_cnt, msg_blk_cnt;

  int sb[$];
  int ps_cyc[$];
  int n_cmp, n_bad, ndone, pcnt, cyc, t0;
  bit exp_dec;

  ascon_aead128_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .no_ad(no_ad),
    .ad_valid(ad_valid), .ad_last(ad_last), .ad_ready(ad_ready),
    .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .dec_mode(dec_mode), .dp_load_init(dp_load_init), .dp_key_xor_tail(dp_key_xor_tail),
    .dp_absorb_ad(dp_absorb_ad), .dp_dsep(dp_dsep), .dp_absorb_msg(dp_absorb_msg),
    .dp_key_xor_final(dp_key_xor_final), .dp_tag_out(dp_tag_out),
    .perm_start(perm_start), .perm_rounds(perm_rounds), .perm_done(perm_done),
    .busy(busy), .done(done), .ad_blk_cnt(ad_blk_cnt), .msg_blk_cnt(msg_blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, required event within cycle budget", nm);
  endtask

  task automatic ev(input int code);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got %0d required none (cycle %0d)", code, cyc);
    end else begin
      int e;
      e = sb.pop_front();
      chk("event", code, e);
      chk("dec_mode", int'(dec_mode), int'(exp_dec));
    end
  endtask

  // permutation model: perm_done pulses exactly perm_rounds cycles after perm_start
  initial begin
    pcnt = 0;
    perm_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      perm_done = 1'b0;
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) perm_done = 1'b1;
      end
      if (perm_start) pcnt = int'(perm_rounds);
    end
  end

  // monitor: every strobe is popped against the expected sequence
  initial begin
    int n;
    ndone = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n = int'(dp_load_init) + int'(dp_key_xor_tail) + int'(dp_absorb_ad) + int'(dp_dsep)
          + int'(dp_absorb_msg) + int'(dp_key_xor_final) + int'(dp_tag_out);
        if (n > 1) chk("one_strobe", n, 1);
        if (done || dp_tag_out) chk("done_eq_tag", int'(done), int'(dp_tag_out));
        if (dp_load_init)     ev(E_LOAD);
        if (dp_key_xor_tail)  ev(E_TAIL);
        if (dp_absorb_ad)     ev(E_AD);
        if (dp_dsep)          ev(E_DSEP);
        if (dp_absorb_msg)    ev(E_MSG);
        if (dp_key_xor_final) ev(E_FIN);
        if (dp_tag_out)       ev(E_TAG);
        if (perm_start) begin
          ps_cyc.push_back(cyc);
          ev(E_PERM + int'(perm_rounds));
        end
        if (done) ndone++;
      end
    end
  end

  task automatic push_op(input int n_ad, input int n_msg);
    sb.push_back(E_LOAD);
    sb.push_back(E_PERM + 12);
    sb.push_back(E_TAIL);
    for (int i = 0; i < n_ad; i++) begin
      sb.push_back(E_AD);
      sb.push_back(E_PERM + 8);
    end
    sb.push_back(E_DSEP);
    for (int i = 0; i < n_msg; i++) begin
      sb.push_back(E_MSG);
      if (i < n_msg - 1) sb.push_back(E_PERM + 8);
    end
    sb.push_back(E_FIN);
    sb.push_back(E_PERM + 12);
    sb.push_back(E_TAG);
  endtask

  task automatic start_op(input bit dec, input bit noad);
    @(posedge clk);
    #2;
    start = 1'b1;
    decrypt = dec;
    no_ad = noad;
    exp_dec = dec;
    t0 = cyc;
    ps_cyc.delete();
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic send_ad(input bit last);
    int k;
    ad_valid = 1'b1;
    ad_last = last;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (ad_ready) break;
      k++;
    end
    if (k >= 200) timeout_fail("ad_handshake");
    @(posedge clk);
    #2;
    ad_valid = 1'b0;
    ad_last = 1'b0;
  endtask

  task automatic send_msg(input bit last, input int gap);
    int k;
    if (gap > 0) begin
      msg_valid = 1'b0;
      k = 0;
      while (k < 200) begin
        @(negedge clk);
        if (msg_ready) break;
        k++;
      end
      if (k >= 200) timeout_fail("msg_ready_wait");
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("gap_msg_ready", int'(msg_ready), 1);
        chk("gap_busy", int'(busy), 1);
      end
      @(posedge clk);
      #2;
    end
    msg_valid = 1'b1;
    msg_last = last;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (msg_ready) break;
      k++;
    end
    if (k >= 200) timeout_fail("msg_handshake");
    @(posedge clk);
    #2;
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int k;
    k = 0;
    dc = -1;
    while (k < 300) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= 300) timeout_fail("done_wait");
    else dc = cyc;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_flags"}, int'({busy, ad_ready, msg_ready, dec_mode, dp_load_init, dp_key_xor_tail,
                              dp_absorb_ad, dp_dsep, dp_absorb_msg, dp_key_xor_final, dp_tag_out,
                              perm_start, done, perm_rounds}), 0);
    chk({nm, "_ad_cnt"}, int'(ad_blk_cnt), 0);
    chk({nm, "_msg_cnt"}, int'(msg_blk_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd0;
    n_cmp = 0;
    n_bad = 0;
    exp_dec = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    no_ad = 1'b0;
    ad_valid = 1'b0;
    ad_last = 1'b0;
    msg_valid = 1'b0;
    msg_last = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // no AD, single last message block offered together with start
    push_op(0, 1);
    msg_valid = 1'b1;
    msg_last = 1'b1;
    start_op(1'b0, 1'b1);
    send_msg(1'b1, 0);
    wait_done(dc);
    chk("t1_done_latency", dc - t0, 32);
    chk("t1_perm_count", ps_cyc.size(), 2);
    if (ps_cyc.size() == 2) begin
      chk("t1_perm0_at", ps_cyc[0] - t0, 2);
      chk("t1_perm1_at", ps_cyc[1] - t0, 19);
    end
    chk("t1_msg_cnt", int'(msg_blk_cnt), 1);

    // two AD blocks and three message blocks
    push_op(2, 3);
    start_op(1'b0, 1'b0);
    send_ad(1'b0);
    send_ad(1'b1);
    send_msg(1'b0, 0);
    send_msg(1'b0, 0);
    send_msg(1'b1, 0);
    wait_done(dc);
    chk("t2_ad_cnt", int'(ad_blk_cnt), 2);
    chk("t2_msg_cnt", int'(msg_blk_cnt), 3);

    // message withheld for 5 cycles in MSG_WAIT
    push_op(0, 2);
    start_op(1'b0, 1'b1);
    send_msg(1'b0, 5);
    send_msg(1'b1, 0);
    wait_done(dc);
    chk("t3_msg_cnt", int'(msg_blk_cnt), 2);

    // start pulsed during FIN_PERM must be ignored
    nd0 = ndone;
    push_op(1, 1);
    start_op(1'b0, 1'b0);
    send_ad(1'b1);
    send_msg(1'b1, 0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    start = 1'b1;
    decrypt = 1'b1;
    no_ad = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    decrypt = 1'b0;
    no_ad = 1'b0;
    wait_done(dc);
    repeat (40) @(posedge clk);
    #2;
    chk("t4_single_done", ndone - nd0, 1);
    chk("t4_ad_cnt", int'(ad_blk_cnt), 1);
    chk("t4_msg_cnt", int'(msg_blk_cnt), 1);
    chk("t4_idle", int'(busy), 0);
    chk("t4_dec_mode", int'(dec_mode), 0);

    // reset while in AD_PERM aborts with no further strobes
    sb.push_back(E_LOAD);
    sb.push_back(E_PERM + 12);
    sb.push_back(E_TAIL);
    sb.push_back(E_AD);
    sb.push_back(E_PERM + 8);
    start_op(1'b0, 1'b0);
    send_ad(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    pcnt = 0;
    @(negedge clk);
    chk_idle("t5_abort");
    chk("t5_sb_drained", sb.size(), 0);
    push_op(0, 1);
    msg_valid = 1'b1;
    msg_last = 1'b1;
    start_op(1'b0, 1'b1);
    send_msg(1'b1, 0);
    wait_done(dc);
    chk("t5_restart_latency", dc - t0, 32);

    // decrypt follows the identical sequence with dec_mode held
    push_op(1, 2);
    start_op(1'b1, 1'b0);
    send_ad(1'b1);
    send_msg(1'b0, 0);
    send_msg(1'b1, 0);
    wait_done(dc);
    chk("t6_dec_mode", int'(dec_mode), 1);
    chk("t6_msg_cnt", int'(msg_blk_cnt), 2);

    repeat (5) @(posedge clk);
    #2;
    chk("final_sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
